// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the bit serializer.
// Optional feature macro used by this block: SEQ_SER_LSB_FIRST_EN (LSB-first emission).
package seq_ser_pkg;

   typedef enum logic [0:0] {
      SER_IDLE  = 1'b0,
      SER_SHIFT = 1'b1
   } ser_state_e;

   localparam int unsigned SER_FIFO_DEPTH = 2;

   // Bit counter width for a word of word_w bits; at least one bit.
   function automatic int unsigned ser_cnt_width(input int unsigned word_w);
      return (word_w < 2) ? 1 : $clog2(word_w);
   endfunction

endpackage

// File: rtl/seq_ser_fifo.sv
// Two-entry synchronous FIFO buffering parallel words ahead of the shifter.
module seq_ser_fifo
   import seq_ser_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(SER_FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(SER_FIFO_DEPTH + 1);

   logic [WIDTH-1:0] mem [SER_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty so no reset is needed.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(SER_FIFO_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the bit-stream sequence detectors.
// Words are buffered in a 2-entry FIFO and shifted out one bit per clock,
// back-to-back with no idle cycle between consecutive words.
// Optional feature macro: SEQ_SER_LSB_FIRST_EN (defined: LSB first; undefined: MSB first).
module seq_bit_serializer
   import seq_ser_pkg::*;
#(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WORD_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              bit_o,
   output logic              bit_vld_o,
   output logic              word_done_o,
   output logic              busy_o
);

   localparam int unsigned       CNT_W    = ser_cnt_width(WORD_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);

   ser_state_e        state_q, state_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rdy_en_q;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W-1:0] fifo_rdata;

   assign fifo_push = valid_i && ready_o;

   seq_ser_fifo #(
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .wdata  (data_i),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Shifter state, word register, bit counter and post-reset ready enable.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= SER_IDLE;
         sh_q     <= '0;
         cnt_q    <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         rdy_en_q <= 1'b1;
      end
   end

   // Next-state logic: load from the FIFO when idle or on the last bit, else shift.
   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;
      case (state_q)
         SER_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sh_d     = fifo_rdata;
               cnt_d    = '0;
               state_d  = SER_SHIFT;
            end
         end
         SER_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  sh_d     = fifo_rdata;
               end else begin
                  state_d = SER_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
`ifdef SEQ_SER_LSB_FIRST_EN
               sh_d  = {1'b0, sh_q[WORD_W-1:1]};
`else
               sh_d  = {sh_q[WORD_W-2:0], 1'b0};
`endif
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   // Output decode from registered state only; the idle line is forced low.
   assign bit_vld_o   = (state_q == SER_SHIFT);
`ifdef SEQ_SER_LSB_FIRST_EN
   assign bit_o       = bit_vld_o && sh_q[0];
`else
   assign bit_o       = bit_vld_o && sh_q[WORD_W-1];
`endif
   assign word_done_o = bit_vld_o && (cnt_q == CNT_LAST);
   assign busy_o      = bit_vld_o || !fifo_empty;
   assign ready_o     = rdy_en_q && !fifo_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer (honours SEQ_SER_LSB_FIRST_EN).
module tb_seq_bit_serializer;

   localparam int W = 8;

   logic         clk_i;
   logic         rst_ni;
   logic [W-1:0] data_i;
   logic         valid_i;
   logic         ready_o;
   logic         bit_o;
   logic         bit_vld_o;
   logic         word_done_o;
   logic         busy_o;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_cmp = 0;
   int         n_bad = 0;
   bit         mon_en = 1'b0;
   logic [3:0] det = 4'b0000;
   int         hits = 0;

   seq_bit_serializer #(
      .WORD_W (W)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .bit_o       (bit_o),
      .bit_vld_o   (bit_vld_o),
      .word_done_o (word_done_o),
      .busy_o      (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected serial bits of an accepted word, in emission order.
   function automatic void push_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) begin
         exp_t e;
         int   idx;
`ifdef SEQ_SER_LSB_FIRST_EN
         idx = i;
`else
         idx = W - 1 - i;
`endif
         e.b    = w[idx];
         e.last = (i == W - 1);
         sb.push_back(e);
      end
   endfunction

   // Scoreboard monitor plus a 1011 detector model fed from the serial line.
   always @(negedge clk_i) begin
      if (mon_en) begin
         det = {det[2:0], bit_o};
         if (det == 4'b1011) hits++;
         if (bit_vld_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_extra_bit: got bit_o=%b word_done_o=%b, nothing expected", bit_o, word_done_o);
            end else begin
               mon_e = sb.pop_front();
               n_cmp++;
               if ({bit_o, word_done_o} !== {mon_e.b, mon_e.last}) begin
                  n_bad++;
                  $display("FAIL sb_bit: got bit_o=%b word_done_o=%b, exp %b %b", bit_o, word_done_o, mon_e.b, mon_e.last);
               end
            end
         end else begin
            n_cmp++;
            if ({bit_o, word_done_o} !== 2'b00) begin
               n_bad++;
               $display("FAIL idle_line: got bit_o=%b word_done_o=%b bit_vld_o=%b, exp 0 0", bit_o, word_done_o, bit_vld_o);
            end
         end
         if (rst_ni !== 1'b1) sb.delete();
         else if (valid_i === 1'b1 && ready_o === 1'b1) push_word(data_i);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy_o !== 1'b0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (busy_o !== 1'b0) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: busy_o=%b, exp 0", busy_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      n_cmp++;
      if ({ready_o, bit_o, bit_vld_o, word_done_o, busy_o} !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_vals: got rdy,bit,vld,done,busy=%b, exp 00000",
                  {ready_o, bit_o, bit_vld_o, word_done_o, busy_o});
      end
      mon_en = 1'b1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if (ready_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready_hold: got %b exp 0", ready_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready_rise: got %b exp 1", ready_o);
      end
   endtask

   task automatic test_idle();
      wait_idle();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({ready_o, bit_o, bit_vld_o, word_done_o} !== 4'b1000) begin
            n_bad++;
            $display("FAIL idle_hold c=%0d: got rdy,bit,vld,done=%b exp 1000", c,
                     {ready_o, bit_o, bit_vld_o, word_done_o});
         end
      end
   endtask

   task automatic test_single();
      logic [W-1:0] seq;
      logic         vld_e, bit_e, done_e, busy_e;
`ifdef SEQ_SER_LSB_FIRST_EN
      seq = 8'b0100_1011;
      data_i = 8'hD2;
`else
      seq = 8'b1011_0000;
      data_i = 8'hB0;
`endif
      wait_idle();
      valid_i = 1'b1;
      for (int p = 0; p < 12; p++) begin
         @(negedge clk_i);
         if (p == 0) begin
            n_cmp++;
            if (ready_o !== 1'b1) begin
               n_bad++; $display("FAIL single_ready: got %b exp 1", ready_o);
            end
         end else begin
            vld_e  = (p >= 2 && p <= 9);
            bit_e  = vld_e ? seq[9-p] : 1'b0;
            done_e = (p == 9);
            busy_e = (p <= 9);
            n_cmp++;
            if ({bit_vld_o, bit_o, word_done_o, busy_o} !== {vld_e, bit_e, done_e, busy_e}) begin
               n_bad++;
               $display("FAIL single p=%0d: got vld,bit,done,busy=%b exp %b", p,
                        {bit_vld_o, bit_o, word_done_o, busy_o}, {vld_e, bit_e, done_e, busy_e});
            end
         end
         @(posedge clk_i); #1;
         if (p == 0) valid_i = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic rdy_e, vld_e, done_e;
      wait_idle();
      valid_i = 1'b1;
      data_i  = 8'h3C;
      for (int p = 0; p < 27; p++) begin
         @(negedge clk_i);
         rdy_e  = !(p >= 3 && p <= 9);
         vld_e  = (p >= 2 && p <= 25);
         done_e = (p == 9 || p == 17 || p == 25);
         n_cmp++;
         if ({ready_o, bit_vld_o, word_done_o} !== {rdy_e, vld_e, done_e}) begin
            n_bad++;
            $display("FAIL b2b p=%0d: got rdy,vld,done=%b exp %b", p,
                     {ready_o, bit_vld_o, word_done_o}, {rdy_e, vld_e, done_e});
         end
         @(posedge clk_i); #1;
         case (p)
            0:       data_i = 8'hC3;
            1:       data_i = 8'h96;
            2:       valid_i = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic test_cross_boundary();
      int h0;
      wait_idle();
      h0 = hits;
      valid_i = 1'b1;
`ifdef SEQ_SER_LSB_FIRST_EN
      data_i = 8'b1010_0000;
`else
      data_i = 8'b0000_0101;
`endif
      @(posedge clk_i); #1;
`ifdef SEQ_SER_LSB_FIRST_EN
      data_i = 8'b0000_0001;
`else
      data_i = 8'b1000_0000;
`endif
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (20) @(negedge clk_i);
      n_cmp++;
      if (hits - h0 != 1) begin
         n_bad++; $display("FAIL cross_boundary_hits: got %0d exp 1", hits - h0);
      end
   endtask

   task automatic test_reset_midword();
      wait_idle();
      valid_i = 1'b1;
      data_i  = 8'hFF;
      @(posedge clk_i); #1;
      data_i  = 8'hFF;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if (bit_vld_o !== 1'b1) begin
         n_bad++; $display("FAIL midword_active: got vld=%b exp 1", bit_vld_o);
      end
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      n_cmp++;
      if ({bit_vld_o, bit_o, busy_o, ready_o, word_done_o} !== 5'b00000) begin
         n_bad++;
         $display("FAIL midword_reset: got vld,bit,busy,rdy,done=%b exp 00000",
                  {bit_vld_o, bit_o, busy_o, ready_o, word_done_o});
      end
      @(negedge clk_i);
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_bad++; $display("FAIL midword_ready: got %b exp 1", ready_o);
      end
      for (int c = 0; c < 12; c++) begin
         @(negedge clk_i);
         n_cmp++;
         if ({bit_vld_o, busy_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL midword_remnant c=%0d: got vld,busy=%b exp 00", c, {bit_vld_o, busy_o});
         end
      end
   endtask

   initial begin
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      data_i  = '0;
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_cross_boundary();
      test_reset_midword();
      test_idle();
      @(negedge clk_i);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++; $display("FAIL sb_leftover: got %0d pending bits exp 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. Accepts WORD_W-bit words over a valid/ready handshake, buffers up to two words, and shifts them out one bit per clock on a single-bit stream that drives the detector's data input directly. Consecutive words are emitted with no idle cycle between them, so a pattern spanning a word boundary reaches the detector exactly as it would from a true serial source.

## Interface
- WORD_W, 8, bits per input word; legal range 2..32
- clk_i  input  1  clock; all logic on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- data_i  input  WORD_W  parallel word to serialize
- valid_i  input  1  data_i is valid this cycle
- ready_o  output  1  block can accept a word this cycle
- bit_o  output  1  serial data bit; connects to the detector's d_i
- bit_vld_o  output  1  bit_o carries a word bit this cycle
- word_done_o  output  1  one-cycle pulse while the last bit of a word is on bit_o
- busy_o  output  1  shifter active or FIFO non-empty

## Operation
- Handshake: a word is accepted at a rising edge where valid_i && ready_o. ready_o = !fifo_full. A push and a pop in the same cycle are both honoured.
- FIFO: 2 entries, first in first out. Overflow cannot occur because ready_o gates every push. Data is never dropped or duplicated.
- Shifter FSM states: IDLE and SHIFT.
  - IDLE: bit_vld_o=0, bit_o=0. If the FIFO is non-empty, pop its head into sh_reg, set cnt=0, and go to SHIFT.
  - SHIFT: bit_o is the current bit of sh_reg and bit_vld_o=1. On each edge, cnt increments.
  - When cnt==WORD_W-1, word_done_o=1. At that edge, if the FIFO is non-empty, pop and reload with cnt=0 and stay in SHIFT. Otherwise go to IDLE.
- Bit order: MSB first by default (see Configuration).
- Counter width: $clog2(WORD_W). cnt never exceeds WORD_W-1.
- Idle line: bit_o is forced to 0 whenever bit_vld_o=0. The detector sees idle cycles as 0 bits. This is intended.
- busy_o = (state==SHIFT) || !fifo_empty.
- Reset (rst_ni=0 at an edge), including mid-word: the FIFO is emptied, state goes to IDLE, cnt=0, and any word in flight is discarded.
  - Reset values: ready_o=0, bit_o=0, bit_vld_o=0, word_done_o=0, busy_o=0.
  - ready_o returns to 1 in the first cycle after rst_ni is sampled high.

## Timing
- All outputs are registered or decoded only from registered state. There is no combinational path from valid_i or data_i to any output.
- Latency: a word accepted at edge N into an empty block puts its first bit on bit_o in the cycle after edge N+1 (2 cycles).
- Throughput: 1 bit per clock. Back-to-back words are contiguous: the first bit of word k+1 directly follows the last bit of word k, provided word k+1 was accepted before word k's last edge.
- ready_o falls in the cycle after the second word is buffered. It rises in the cycle after the pop that frees an entry.

## Configuration
- SEQ_SER_LSB_FIRST_EN
  - Defined: bits are emitted LSB first, so the first bit out is data_i[0].
  - Undefined: bits are emitted MSB first, so the first bit out is data_i[WORD_W-1].
  - Handshake, latency and word_done_o timing are identical in both modes.

## Structure
- Package seq_ser_pkg holds:
  - the state enum (SER_IDLE, SER_SHIFT);
  - localparam SER_FIFO_DEPTH = 2;
  - the counter width function.
- Sub-module seq_ser_fifo: a 2-entry synchronous FIFO with push, pop, full and empty signals, using the same clk_i/rst_ni.
- The top level holds the shifter FSM, sh_reg, cnt and output decode.

## Test plan
- Single word, WORD_W=8, data_i=8'b1011_0000 accepted at edge 0:
  - bit_o = 1,0,1,1,0,0,0,0 in cycles 2..9;
  - bit_vld_o high exactly those 8 cycles;
  - word_done_o high in cycle 9 only;
  - busy_o falls after cycle 9.
- valid_i held high with words A, B, C:
  - accepts at edges 0, 1, 2; ready_o low from cycle 3;
  - 24 contiguous valid bits with no gap at word boundaries;
  - ready_o high again the cycle after A's last edge.
- Cross-boundary pattern: words 8'b0000_0101 then 8'b1000_0000, back-to-back, MSB first. Stream contains ...1,0,1,1... across the boundary and drives the 1011 detector to a hit.
- Reset mid-word: rst_ni low for 1 cycle during bit 4 of a word, with one word buffered.
  - Next cycle: bit_vld_o=0, bit_o=0, busy_o=0.
  - The cycle after: ready_o=1.
  - No remnant bits appear.
- With SEQ_SER_LSB_FIRST_EN defined, data_i=8'hD2 gives bit_o = 0,1,0,0,1,0,1,1, with the same cycle positions as the single-word scenario.
- Idle and valid_i low for 20 cycles: ready_o=1, bit_o=0, bit_vld_o=0, word_done_o=0 throughout.
